// File: rtl/clusterv_tile_sram_banked.sv
// Banked two-port SRAM tile: port 0 read/write, port 1 read-only.
// Words interleave across N_BANKS by the low address bits. Each bank is a
// single-port array, and a 1-bit round-robin pointer arbitrates same-bank
// collisions. Read data is registered once, with an optional second stage.
module clusterv_tile_sram_banked #(
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int N_BANKS    = 2,
  parameter int OUT_REG    = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   t0_csb,
  input  logic                   t0_web,
  input  logic [DAT_WIDTH/8-1:0] t0_wmask,
  input  logic [ADDR_WIDTH-1:0]  t0_addr,
  input  logic [DAT_WIDTH-1:0]   t0_dat_w,
  output logic [DAT_WIDTH-1:0]   t0_dat_r,
  output logic                   t0_rvalid,
  output logic                   t0_stall,
  input  logic                   t1_csb,
  input  logic [ADDR_WIDTH-1:0]  t1_addr,
  output logic [DAT_WIDTH-1:0]   t1_dat_r,
  output logic                   t1_rvalid,
  output logic                   t1_stall
);
  localparam int NBYTE = DAT_WIDTH / 8;
  localparam int BB    = (N_BANKS > 1) ? $clog2(N_BANKS) : 0;
  localparam int BW    = (BB > 0) ? BB : 1;
  localparam int ROW_W = ADDR_WIDTH - BB;
  localparam int ROWS  = 1 << ROW_W;

  logic [1:0][ADDR_WIDTH-1:0]        w_addr;
  logic [1:0][BW-1:0]                w_bank;
  logic [1:0][ROW_W-1:0]             w_row;
  logic [1:0]                        w_req, w_stall, w_acc, w_rd;
  logic                              w_conflict, w_wr;
  logic                              r_rr;
  logic [N_BANKS-1:0][DAT_WIDTH-1:0] w_bank_rdata;
  logic [1:0][DAT_WIDTH-1:0]         w_rdata;
  logic [1:0]                        w_rvalid;

  assign w_addr[0] = t0_addr;
  assign w_addr[1] = t1_addr;

  // Requests are masked while reset is high so nothing is accepted or stalled.
  assign w_req[0] = ~t0_csb & ~reset;
  assign w_req[1] = ~t1_csb & ~reset;

  for (genvar p = 0; p < 2; p++) begin : g_split
    if (BB > 0) begin : g_bank
      assign w_bank[p] = w_addr[p][BW-1:0];
    end else begin : g_nobank
      assign w_bank[p] = '0;
    end
    assign w_row[p] = w_addr[p][ADDR_WIDTH-1:BB];
  end

  // r_rr == 0 means port 0 wins the next collision.
  assign w_conflict = w_req[0] & w_req[1] & (w_bank[0] == w_bank[1]);
  assign w_stall[0] = w_conflict &  r_rr;
  assign w_stall[1] = w_conflict & ~r_rr;
  assign w_acc      = w_req & ~w_stall;
  assign w_wr       = w_acc[0] & ~t0_web;
  assign w_rd[0]    = w_acc[0] &  t0_web;
  assign w_rd[1]    = w_acc[1];

  assign t0_stall = w_stall[0];
  assign t1_stall = w_stall[1];

  // Pointer hands priority to the loser, only when a collision actually happened.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           r_rr <= 1'b0;
    else if (w_conflict) r_rr <= ~r_rr;
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank_arr
    logic [DAT_WIDTH-1:0] r_mem [ROWS];
    logic                 w_sel1;
    logic [ROW_W-1:0]     w_brow;

    // Arbitration guarantees at most one accepted port per bank per cycle.
    assign w_sel1          = w_acc[1] & (w_bank[1] == BW'(b));
    assign w_brow          = w_sel1 ? w_row[1] : w_row[0];
    assign w_bank_rdata[b] = r_mem[w_brow];

    // Byte-masked write. A same-edge read samples the pre-write word.
    always_ff @(posedge clock) begin
      if (w_wr && (w_bank[0] == BW'(b))) begin
        for (int i = 0; i < NBYTE; i++) begin
          if (t0_wmask[i]) r_mem[w_row[0]][i*8 +: 8] <= t0_dat_w[i*8 +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                 r_vld1;
    logic [DAT_WIDTH-1:0] r_dat1;

    // First read stage captures only on an accepted read, so data holds between reads.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_vld1 <= 1'b0;
        r_dat1 <= '0;
      end else begin
        r_vld1 <= w_rd[p];
        if (w_rd[p]) r_dat1 <= w_bank_rdata[w_bank[p]];
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic                 r_vld2;
      logic [DAT_WIDTH-1:0] r_dat2;

      // Optional output stage advances only behind a valid first stage.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_vld2 <= 1'b0;
          r_dat2 <= '0;
        end else begin
          r_vld2 <= r_vld1;
          if (r_vld1) r_dat2 <= r_dat1;
        end
      end
      assign w_rvalid[p] = r_vld2;
      assign w_rdata[p]  = r_dat2;
    end else begin : g_noreg
      assign w_rvalid[p] = r_vld1;
      assign w_rdata[p]  = r_dat1;
    end
  end

  assign t0_rvalid = w_rvalid[0];
  assign t0_dat_r  = w_rdata[0];
  assign t1_rvalid = w_rvalid[1];
  assign t1_dat_r  = w_rdata[1];
endmodule

// File: tb/tb_clusterv_tile_sram_banked.sv
// Directed bench: default tile (u_a), OUT_REG=1 tile (u_b), N_BANKS=4 tile (u_c).
module tb_clusterv_tile_sram_banked;
  logic clk = 1'b0;
  logic rst;

  logic        a_t0_csb, a_t0_web, a_t1_csb, a_t0_rvalid, a_t0_stall, a_t1_rvalid, a_t1_stall;
  logic [3:0]  a_t0_wmask;
  logic [7:0]  a_t0_addr, a_t1_addr;
  logic [31:0] a_t0_dat_w, a_t0_dat_r, a_t1_dat_r;

  logic        b_t0_csb, b_t0_web, b_t1_csb, b_t0_rvalid, b_t0_stall, b_t1_rvalid, b_t1_stall;
  logic [3:0]  b_t0_wmask;
  logic [7:0]  b_t0_addr, b_t1_addr;
  logic [31:0] b_t0_dat_w, b_t0_dat_r, b_t1_dat_r;

  logic        c_t0_csb, c_t0_web, c_t1_csb, c_t0_rvalid, c_t0_stall, c_t1_rvalid, c_t1_stall;
  logic [3:0]  c_t0_wmask;
  logic [7:0]  c_t0_addr, c_t1_addr;
  logic [31:0] c_t0_dat_w, c_t0_dat_r, c_t1_dat_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  clusterv_tile_sram_banked u_a (
    .clock(clk), .reset(rst),
    .t0_csb(a_t0_csb), .t0_web(a_t0_web), .t0_wmask(a_t0_wmask), .t0_addr(a_t0_addr),
    .t0_dat_w(a_t0_dat_w), .t0_dat_r(a_t0_dat_r), .t0_rvalid(a_t0_rvalid), .t0_stall(a_t0_stall),
    .t1_csb(a_t1_csb), .t1_addr(a_t1_addr), .t1_dat_r(a_t1_dat_r), .t1_rvalid(a_t1_rvalid),
    .t1_stall(a_t1_stall));

  clusterv_tile_sram_banked #(.OUT_REG(1)) u_b (
    .clock(clk), .reset(rst),
    .t0_csb(b_t0_csb), .t0_web(b_t0_web), .t0_wmask(b_t0_wmask), .t0_addr(b_t0_addr),
    .t0_dat_w(b_t0_dat_w), .t0_dat_r(b_t0_dat_r), .t0_rvalid(b_t0_rvalid), .t0_stall(b_t0_stall),
    .t1_csb(b_t1_csb), .t1_addr(b_t1_addr), .t1_dat_r(b_t1_dat_r), .t1_rvalid(b_t1_rvalid),
    .t1_stall(b_t1_stall));

  clusterv_tile_sram_banked #(.N_BANKS(4)) u_c (
    .clock(clk), .reset(rst),
    .t0_csb(c_t0_csb), .t0_web(c_t0_web), .t0_wmask(c_t0_wmask), .t0_addr(c_t0_addr),
    .t0_dat_w(c_t0_dat_w), .t0_dat_r(c_t0_dat_r), .t0_rvalid(c_t0_rvalid), .t0_stall(c_t0_stall),
    .t1_csb(c_t1_csb), .t1_addr(c_t1_addr), .t1_dat_r(c_t1_dat_r), .t1_rvalid(c_t1_rvalid),
    .t1_stall(c_t1_stall));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_t0_csb = 1'b1; a_t0_web = 1'b1; a_t0_wmask = 4'h0; a_t0_addr = 8'h00; a_t0_dat_w = 32'h0;
    a_t1_csb = 1'b1; a_t1_addr = 8'h00;
    b_t0_csb = 1'b1; b_t0_web = 1'b1; b_t0_wmask = 4'h0; b_t0_addr = 8'h00; b_t0_dat_w = 32'h0;
    b_t1_csb = 1'b1; b_t1_addr = 8'h00;
    c_t0_csb = 1'b1; c_t0_web = 1'b1; c_t0_wmask = 4'h0; c_t0_addr = 8'h00; c_t0_dat_w = 32'h0;
    c_t1_csb = 1'b1; c_t1_addr = 8'h00;
  endtask

  task automatic a_wr(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] m);
    a_t0_csb = 1'b0; a_t0_web = 1'b0; a_t0_addr = addr; a_t0_dat_w = d; a_t0_wmask = m;
    @(negedge clk);
    chk("a_wr_stall", a_t0_stall, 1'b0);
    step();
    a_t0_csb = 1'b1; a_t0_web = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    // Requests while in reset: ignored, no stall even with a same-bank collision.
    a_t0_csb = 1'b0; a_t1_csb = 1'b0; a_t0_addr = 8'h04; a_t1_addr = 8'h04;
    @(negedge clk);
    chk("rst_t0_stall", a_t0_stall, 1'b0);
    chk("rst_t1_stall", a_t1_stall, 1'b0);
    chk("rst_t0_rvalid", a_t0_rvalid, 1'b0);
    chk("rst_t0_dat", a_t0_dat_r, 32'h0);
    chk("rst_t1_dat", a_t1_dat_r, 32'h0);
    chk("rst_b_t1_rvalid", b_t1_rvalid, 1'b0);
    step();
    rst = 1'b0;

    // Same-bank collisions from reset: port 0 wins first, then alternation.
    @(negedge clk);
    chk("rr_c1_t1_stall", a_t1_stall, 1'b1);
    chk("rr_c1_t0_stall", a_t0_stall, 1'b0);
    step();
    @(negedge clk);
    chk("rr_c2_t0_stall", a_t0_stall, 1'b1);
    chk("rr_c2_t1_stall", a_t1_stall, 1'b0);
    chk("rr_c2_t0_rvalid", a_t0_rvalid, 1'b1);
    step();
    @(negedge clk);
    chk("rr_c3_t1_stall", a_t1_stall, 1'b1);
    chk("rr_c3_t0_stall", a_t0_stall, 1'b0);
    chk("rr_c3_t1_rvalid", a_t1_rvalid, 1'b1);
    chk("rr_c3_t0_rvalid", a_t0_rvalid, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk("idle_t0_stall", a_t0_stall, 1'b0);

    // Byte-masked writes, then read back.
    a_wr(8'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("wr_no_rvalid", a_t0_rvalid, 1'b0);
    a_wr(8'h10, 32'h00005500, 4'h2);
    a_wr(8'h10, 32'hFFFFFFFF, 4'h0);
    a_t0_csb = 1'b0; a_t0_web = 1'b1; a_t0_addr = 8'h10;
    @(negedge clk);
    chk("rd10_stall", a_t0_stall, 1'b0);
    chk("rd10_pre_rvalid", a_t0_rvalid, 1'b0);
    step();
    a_t0_csb = 1'b1;
    @(negedge clk);
    chk("rd10_rvalid", a_t0_rvalid, 1'b1);
    chk("rd10_dat", a_t0_dat_r, 32'hDEAD55EF);
    step();
    @(negedge clk);
    chk("rd10_rvalid_drop", a_t0_rvalid, 1'b0);
    chk("rd10_dat_hold", a_t0_dat_r, 32'hDEAD55EF);

    // Different banks in the same cycle are both accepted.
    a_wr(8'h02, 32'h11112222, 4'hF);
    a_wr(8'h03, 32'h33334444, 4'hF);
    a_t0_csb = 1'b0; a_t0_web = 1'b1; a_t0_addr = 8'h02;
    a_t1_csb = 1'b0; a_t1_addr = 8'h03;
    @(negedge clk);
    chk("dual_t0_stall", a_t0_stall, 1'b0);
    chk("dual_t1_stall", a_t1_stall, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk("dual_t0_rvalid", a_t0_rvalid, 1'b1);
    chk("dual_t1_rvalid", a_t1_rvalid, 1'b1);
    chk("dual_t0_dat", a_t0_dat_r, 32'h11112222);
    chk("dual_t1_dat", a_t1_dat_r, 32'h33334444);

    // OUT_REG=1: fill 0..7, then eight back-to-back port-1 reads.
    for (int i = 0; i < 8; i++) begin
      b_t0_csb = 1'b0; b_t0_web = 1'b0; b_t0_wmask = 4'hF;
      b_t0_addr = 8'(i); b_t0_dat_w = 32'hA5000000 + 32'(i) * 32'h00010101;
      step();
    end
    idle();
    @(negedge clk);
    chk("b_wr_no_rvalid", b_t1_rvalid, 1'b0);
    step();
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        b_t1_csb = 1'b0; b_t1_addr = 8'(c);
      end else begin
        b_t1_csb = 1'b1;
      end
      @(negedge clk);
      if (c < 8) chk("b_rd_stall", b_t1_stall, 1'b0);
      chk("b_rvalid", b_t1_rvalid, (c >= 2 && c < 10) ? 1'b1 : 1'b0);
      if (c >= 2 && c < 10) chk("b_dat", b_t1_dat_r, 32'hA5000000 + 32'(c - 2) * 32'h00010101);
      step();
    end
    idle();

    // Four banks: write 0x05 and read 0x06 together, then read 0x05 back.
    c_t0_csb = 1'b0; c_t0_web = 1'b0; c_t0_wmask = 4'hF; c_t0_addr = 8'h06; c_t0_dat_w = 32'h66666666;
    step();
    c_t0_addr = 8'h05; c_t0_dat_w = 32'hCAFEF00D;
    c_t1_csb = 1'b0; c_t1_addr = 8'h06;
    @(negedge clk);
    chk("c_t0_stall", c_t0_stall, 1'b0);
    chk("c_t1_stall", c_t1_stall, 1'b0);
    step();
    c_t1_csb = 1'b1;
    c_t0_web = 1'b1; c_t0_addr = 8'h05;
    @(negedge clk);
    chk("c_t1_rvalid", c_t1_rvalid, 1'b1);
    chk("c_t1_dat", c_t1_dat_r, 32'h66666666);
    chk("c_t0_wr_no_rvalid", c_t0_rvalid, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk("c_rd5_rvalid", c_t0_rvalid, 1'b1);
    chk("c_rd5_dat", c_t0_dat_r, 32'hCAFEF00D);
    step();

    // Reset right after a read is accepted discards it.
    a_t0_csb = 1'b0; a_t0_web = 1'b1; a_t0_addr = 8'h03;
    step();
    rst = 1'b1;
    a_t0_csb = 1'b1;
    @(negedge clk);
    chk("mid_rst_rvalid", a_t0_rvalid, 1'b0);
    chk("mid_rst_dat", a_t0_dat_r, 32'h0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_rvalid", a_t0_rvalid, 1'b0);
      chk("post_rst_dat", a_t0_dat_r, 32'h0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
